digitrev_pingpong: RTL and testbench

Parametrised, double-buffered reorder stage that generalises the single-frame bit-reversal core. It accepts natural-order samples on a valid/ready stream and emits each frame in bit-reversed, radix-4 digit-reversed or natural order. Frame length is selectable at runtime, per frame, up to 2^KMAX. It sits between the sample source and the FFT datapath, and ping-pong banks let frame n+1 be written while frame n is read.

---
 rtl/digitrev_pingpong.sv | 211 +++++++++++++++++++++
 tb/tb_digitrev_pingpong.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digitrev_pingpong.sv
// rtl/digitrev_pingpong.sv - ping-pong reorder buffer emitting frames in bit-reversed, radix-4 digit-reversed or natural order
// Two banks alternate between writing and reading; each bank carries the frame size and order it was written with.
module digitrev_pingpong #(
  parameter int KMAX = 10,
  parameter int DW   = 32,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [KW-1:0] cfg_k_i,
  input  logic [1:0]    cfg_mode_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  input  logic          ready_i,
  output logic          cfg_err_o
);

  localparam int DEPTH = 1 << KMAX;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] M_BIT = 2'd0;
  localparam logic [1:0] M_DIG = 2'd1;
  localparam logic [1:0] M_NAT = 2'd2;

  // Index of the last word of a 2^k frame.
  function automatic logic [KMAX-1:0] f_mask(input logic [KW-1:0] k);
    f_mask = {KMAX{1'b1}} >> (KMAX - int'(k));
  endfunction

  function automatic logic [KMAX-1:0] f_addr(input logic [KMAX-1:0] j,
                                             input logic [KW-1:0]   k,
                                             input logic [1:0]      mode);
    logic [KMAX-1:0] rev;
    logic [KMAX-1:0] dig;
    for (int i = 0; i < KMAX; i++) rev[i] = j[KMAX-1-i];
    rev = rev >> (KMAX - int'(k));
    dig = '0;
    // Digit d of j lands at digit position (k/2 - 1 - d).
    for (int d = 0; d < KMAX / 2; d++) begin
      for (int t = 0; t < KMAX / 2; t++) begin
        if (d + t + 1 == int'(k) / 2) dig[2*t +: 2] = j[2*d +: 2];
      end
    end
    case (mode)
      M_DIG:   f_addr = dig;
      M_NAT:   f_addr = j;
      default: f_addr = rev;
    endcase
  endfunction

  logic [1:0]      r_bstate [2];
  logic [KW-1:0]   r_bk     [2];
  logic [1:0]      r_bmode  [2];
  logic            r_wptr;
  logic [KMAX-1:0] r_waddr;
  logic            r_ready;
  logic            r_cfg_err;
  logic            r_rptr;
  logic            r_rd_active;
  logic [KMAX-1:0] r_rcnt;
  logic            r_relptr;
  logic            r_pend;
  logic            r_pend_last;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_fd [2];
  logic            r_fl [2];
  logic            r_fhead;
  logic [1:0]      r_fcnt;
  logic [DW-1:0]   r_mem [2*DEPTH];

  logic            w_bad_k;
  logic            w_bad_mode;
  logic [KW-1:0]   w_cfg_k;
  logic [1:0]      w_cfg_mode;
  logic            w_wr;
  logic            w_wfirst;
  logic [KW-1:0]   w_wk;
  logic            w_wlast;
  logic            w_wptr_nxt;
  logic [KW-1:0]   w_rk;
  logic [1:0]      w_rmode;
  logic [KMAX-1:0] w_raddr;
  logic            w_pop;
  logic            w_credit;
  logic            w_issue;
  logic            w_ilast;
  logic            w_rstart;
  logic            w_release;
  logic [1:0]      w_bstate_nxt [2];
  logic            w_ready_nxt;

  always_comb begin
    w_bad_k    = (cfg_k_i == '0) || (cfg_k_i > KW'(KMAX));
    w_cfg_k    = w_bad_k ? KW'(KMAX) : cfg_k_i;
    w_bad_mode = (cfg_mode_i == 2'd3) || ((cfg_mode_i == M_DIG) && w_cfg_k[0]);
    w_cfg_mode = w_bad_mode ? M_BIT : cfg_mode_i;
  end

  // Write side: config is taken from the ports only on word 0 of a frame.
  assign w_wr       = valid_i && r_ready;
  assign w_wfirst   = (r_waddr == '0);
  assign w_wk       = w_wfirst ? w_cfg_k : r_bk[r_wptr];
  assign w_wlast    = w_wr && (r_waddr == f_mask(w_wk));
  assign w_wptr_nxt = r_wptr ^ w_wlast;

  // Read issue runs ahead of the output handshake; the 2-entry buffer plus one
  // in-flight RAM read is what lets a word leave every cycle.
  assign w_rk      = r_bk[r_rptr];
  assign w_rmode   = r_bmode[r_rptr];
  assign w_raddr   = f_addr(r_rcnt, w_rk, w_rmode);
  assign w_pop     = valid_o && ready_i;
  assign w_credit  = (3'(r_fcnt) + 3'(r_pend)) <= (3'd1 + 3'(w_pop));
  assign w_issue   = (r_rd_active || (r_bstate[r_rptr] == S_FULL)) && w_credit;
  assign w_ilast   = w_issue && (r_rcnt == f_mask(w_rk));
  assign w_rstart  = w_issue && !r_rd_active;
  assign w_release = w_pop && r_fl[r_fhead];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bstate[0] <= S_EMPTY;
      r_bstate[1] <= S_EMPTY;
    end else begin
      r_bstate[0] <= w_bstate_nxt[0];
      r_bstate[1] <= w_bstate_nxt[1];
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bstate_nxt[b] = r_bstate[b];
      if (w_wr && (r_wptr == 1'(b))) w_bstate_nxt[b] = w_wlast ? S_FULL : S_FILL;
      if (w_rstart && (r_rptr == 1'(b))) w_bstate_nxt[b] = S_DRAIN;
      if (w_release && (r_relptr == 1'(b))) w_bstate_nxt[b] = S_EMPTY;
    end
  end

  always_comb begin
    w_ready_nxt = 1'b0;
    if (!rst_i) begin
      w_ready_nxt = (w_bstate_nxt[w_wptr_nxt] == S_EMPTY) ||
                    (w_bstate_nxt[w_wptr_nxt] == S_FILL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr      <= 1'b0;
      r_waddr     <= '0;
      r_ready     <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_bk[0]     <= KW'(KMAX);
      r_bk[1]     <= KW'(KMAX);
      r_bmode[0]  <= M_BIT;
      r_bmode[1]  <= M_BIT;
      r_rptr      <= 1'b0;
      r_rd_active <= 1'b0;
      r_rcnt      <= '0;
      r_relptr    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_fhead     <= 1'b0;
      r_fcnt      <= 2'd0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_ready   <= w_ready_nxt;
      r_cfg_err <= w_wr && w_wfirst && (w_bad_k || w_bad_mode);
      if (w_wr) begin
        if (w_wfirst) begin
          r_bk[r_wptr]    <= w_cfg_k;
          r_bmode[r_wptr] <= w_cfg_mode;
        end
        r_waddr <= w_wlast ? '0 : r_waddr + KMAX'(1);
      end
      if (w_issue) begin
        r_rcnt      <= w_ilast ? '0 : r_rcnt + KMAX'(1);
        r_rd_active <= !w_ilast;
        r_rptr      <= r_rptr ^ w_ilast;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_ilast;
      r_relptr    <= r_relptr ^ w_release;
      if (w_pop) r_fhead <= ~r_fhead;
      r_fcnt <= r_fcnt + 2'(r_pend) - 2'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[{r_wptr, r_waddr}] <= data_i;
    if (w_issue) r_rdata <= r_mem[{r_rptr, w_raddr}];
    // Tail slot is head+count; still correct when the head is popped this cycle.
    if (r_pend) begin
      r_fd[r_fhead ^ r_fcnt[0]] <= r_rdata;
      r_fl[r_fhead ^ r_fcnt[0]] <= r_pend_last;
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = (r_fcnt != 2'd0);
  assign data_o    = valid_o ? r_fd[r_fhead] : '0;
  assign last_o    = valid_o && r_fl[r_fhead];
  assign cfg_err_o = r_cfg_err;

endmodule

// File: tb/tb_digitrev_pingpong.sv
// tb/tb_digitrev_pingpong.sv - scoreboard bench for digitrev_pingpong
module tb_digitrev_pingpong;
  localparam int KMAX = 10;
  localparam int DW   = 32;
  localparam int KW   = $clog2(KMAX + 1);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [KW-1:0] cfg_k_i = '0;
  logic [1:0]    cfg_mode_i = 2'd0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          ready_i = 1'b1;
  logic          cfg_err_o;

  always #5 clk = ~clk;

  digitrev_pingpong #(.KMAX(KMAX), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cfg_k_i    (cfg_k_i),
    .cfg_mode_i (cfg_mode_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .cfg_err_o  (cfg_err_o)
  );

  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int j, input int k, input int mode);
    int r;
    r = 0;
    if (mode == 2) return j;
    if (mode == 1) begin
      for (int d = 0; d < k / 2; d++) r = (r << 2) | ((j >> (2 * d)) & 3);
    end else begin
      for (int b = 0; b < k; b++) r = (r << 1) | ((j >> b) & 1);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [DW-1:0] d, output bit ok);
    bit acc;
    valid_i = 1'b1;
    data_i  = d;
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      acc = ready_o;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    valid_i = 1'b0;
    if (!ok) chk("input_accept_timeout", ok, 1);
  endtask

  task automatic send_frame(input int k_in, input int mode_in, input int tag,
                            input int max_gap, input bit push, input int nwords);
    int k, mode, n, cnt;
    bit err, ok;
    logic [DW:0] e;
    k = (k_in == 0 || k_in > KMAX) ? KMAX : k_in;
    mode = mode_in;
    if (mode_in == 3 || (mode_in == 1 && (k % 2) == 1)) mode = 0;
    err = (k != k_in) || (mode != mode_in);
    n = 1 << k;
    if (push) begin
      for (int j = 0; j < n; j++) begin
        e = {(j == n - 1) ? 1'b1 : 1'b0, DW'((tag << 16) | exp_addr(j, k, mode))};
        exp_q.push_back(e);
      end
    end
    cfg_k_i    = KW'(k_in);
    cfg_mode_i = 2'(mode_in);
    cnt = (nwords < 0) ? n : nwords;
    for (int i = 0; i < cnt; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send_word(DW'((tag << 16) | i), ok);
      if (!ok) return;
      if (i == 0) begin
        chk("cfg_err_pulse", cfg_err_o, err);
        cfg_k_i    = KW'($urandom_range(0, 15));
        cfg_mode_i = 2'($urandom_range(0, 3));
      end
      if (i == 1) chk("cfg_err_single", cfg_err_o, 0);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int t = 0; t < max_cycles; t++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (8) tick();
  endtask

  // Output monitor: scoreboard pop on each handshake, hold checks while stalled.
  initial begin
    bit prev_stall;
    logic [DW-1:0] prev_d;
    logic prev_l;
    logic [DW:0] e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (!valid_o) chk("last_without_valid", last_o, 0);
        if (prev_stall) begin
          chk("hold_valid", valid_o, 1);
          chk("hold_data", data_o, prev_d);
          chk("hold_last", last_o, prev_l);
        end
        if (valid_o && ready_i) begin
          chk("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", data_o, e[DW-1:0]);
            chk("out_last", last_o, e[DW]);
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_d = data_o;
        prev_l = last_o;
      end
    end
  end

  initial begin
    int bubbles;
    repeat (3) tick();
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", ready_o, 1);

    // k=10 bit reverse: latency and back-to-back output.
    send_frame(10, 0, 0, 0, 1'b1, -1);
    @(negedge clk);
    chk("latency_cycle0", valid_o, 0);
    @(negedge clk);
    chk("latency_cycle1", valid_o, 0);
    @(negedge clk);
    chk("latency_cycle2", valid_o, 1);
    bubbles = 0;
    for (int t = 0; t < 1023; t++) begin
      @(negedge clk);
      if (!valid_o) bubbles++;
    end
    chk("no_bubbles", bubbles, 0);
    wait_drain(200);

    // k=4 radix-4 digit reverse.
    send_frame(4, 1, 1, 0, 1'b1, -1);
    wait_drain(200);

    // Both banks full with downstream stalled.
    ready_i = 1'b0;
    send_frame(3, 0, 2, 0, 1'b1, -1);
    send_frame(10, 2, 3, 0, 1'b1, -1);
    valid_i = 1'b1;
    data_i  = 32'hC0C0_0000;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("both_full_ready_low", ready_o, 0);
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    wait_drain(3000);
    chk("ready_after_release", ready_o, 1);

    // Random backpressure and input gaps.
    rand_rdy = 1'b1;
    send_frame(8, 0, 4, 3, 1'b1, -1);
    wait_drain(4000);
    rand_rdy = 1'b0;
    ready_i = 1'b1;
    tick();

    // Illegal configs and back-to-back frames of differing config.
    send_frame(0, 0, 5, 0, 1'b1, -1);
    send_frame(5, 1, 6, 1, 1'b1, -1);
    send_frame(6, 3, 7, 0, 1'b1, -1);
    send_frame(1, 1, 8, 0, 1'b1, -1);
    send_frame(1, 2, 9, 0, 1'b1, -1);
    wait_drain(4000);

    // Reset in the middle of a frame.
    send_frame(10, 0, 10, 0, 1'b0, 300);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_last", last_o, 0);
    chk("midrst_cfg_err", cfg_err_o, 0);
    tick();
    chk("midrst_ready_after", ready_o, 1);
    send_frame(10, 0, 11, 0, 1'b1, -1);
    wait_drain(2000);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
